// File: rtl/trace_uart_arbiter.sv
// trace_uart_arbiter: shares one UART TX byte channel between CPU serial
// output and a framed stream of 36-bit core trace words.
//
// state | meaning
// IDLE  | nothing in flight; arbitrate CPU byte vs. buffered trace word
// CPU   | CPU byte presented on tx_data, waiting for transfer
// HDR   | frame sync byte presented, trace word held in shift register
// DATA  | trace word bytes presented LSB first, idx = byte on tx_data
//
// A trace frame is header + 5 bytes and is never split by a CPU byte.
module trace_uart_arbiter #(
   parameter int          FIFO_DEPTH   = 16,
   parameter logic [7:0]  FRAME_HEADER = 8'hA5
) (
   input  logic                          clock,
   input  logic                          resetn,
   input  logic                          trace_enable,
   input  logic [35:0]                   trace_data,
   input  logic                          trace_valid,
   input  logic                          cpu_tx_valid,
   input  logic [7:0]                    cpu_tx_data,
   output logic                          cpu_tx_ready,
   output logic                          tx_valid,
   output logic [7:0]                    tx_data,
   input  logic                          tx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [15:0]                   overflow_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {IDLE, CPU, HDR, DATA} state_t;
   typedef enum logic {GRANT_CPU, GRANT_TRACE} grant_t;

   state_t        state, state_next;
   grant_t        last_grant, last_grant_next;
   logic          tx_valid_next;
   logic [7:0]    tx_data_next;
   logic [35:0]   shift, shift_next;
   logic [2:0]    idx, idx_next;
   logic          grant_cpu, grant_trace;
   logic          xfer;

   logic [35:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          fifo_full, fifo_empty;
   logic          wr_req, push, pop, drop;

   assign fifo_full  = (fifo_level == LW'(FIFO_DEPTH));
   assign fifo_empty = (fifo_level == '0);
   assign wr_req     = trace_valid & trace_enable;
   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign push       = wr_req & (~fifo_full | pop);
   assign drop       = wr_req & fifo_full & ~pop;
   assign xfer       = tx_valid & tx_ready;

   // Trace word storage; contents are don't-care until written.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= trace_data;
   end

   // FIFO pointers, occupancy and saturating drop counter.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         fifo_level     <= '0;
         overflow_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: fifo_level <= fifo_level;
         endcase
         if (drop && overflow_count != 16'hFFFF)
            overflow_count <= overflow_count + 16'd1;
      end
   end

   // FSM and output byte registers.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         last_grant <= GRANT_TRACE;
         tx_valid   <= 1'b0;
         tx_data    <= 8'h00;
         shift      <= '0;
         idx        <= '0;
      end else begin
         state      <= state_next;
         last_grant <= last_grant_next;
         tx_valid   <= tx_valid_next;
         tx_data    <= tx_data_next;
         shift      <= shift_next;
         idx        <= idx_next;
      end
   end

   // Arbitration, framing and next-byte selection.
   always_comb begin
      state_next      = state;
      last_grant_next = last_grant;
      tx_valid_next   = tx_valid;
      tx_data_next    = tx_data;
      shift_next      = shift;
      idx_next        = idx;
      grant_cpu       = 1'b0;
      grant_trace     = 1'b0;
      pop             = 1'b0;
      cpu_tx_ready    = 1'b0;

      case (state)
         IDLE: begin
            // Alternate on a tie so neither source starves the other.
            grant_cpu   = cpu_tx_valid & (fifo_empty | (last_grant == GRANT_TRACE));
            grant_trace = ~fifo_empty & ~grant_cpu;
            tx_valid_next = 1'b0;
            if (grant_cpu) begin
               cpu_tx_ready    = 1'b1;
               tx_data_next    = cpu_tx_data;
               tx_valid_next   = 1'b1;
               last_grant_next = GRANT_CPU;
               state_next      = CPU;
            end else if (grant_trace) begin
               pop             = 1'b1;
               shift_next      = mem[rd_ptr];
               tx_data_next    = FRAME_HEADER;
               tx_valid_next   = 1'b1;
               last_grant_next = GRANT_TRACE;
               state_next      = HDR;
            end
         end
         CPU: begin
            if (xfer) begin
               tx_valid_next = 1'b0;
               state_next    = IDLE;
            end
         end
         HDR: begin
            if (xfer) begin
               tx_data_next = shift[7:0];
               shift_next   = shift >> 8;
               idx_next     = 3'd0;
               state_next   = DATA;
            end
         end
         DATA: begin
            // After four shifts the low byte is {4'h0, word[35:32]}.
            if (xfer) begin
               if (idx == 3'd4) begin
                  tx_valid_next = 1'b0;
                  state_next    = IDLE;
               end else begin
                  tx_data_next = shift[7:0];
                  shift_next   = shift >> 8;
                  idx_next     = idx + 3'd1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_trace_uart_arbiter.sv
// Bench for trace_uart_arbiter: table of single transactions, then
// hand-written backpressure, overflow, gating, reset and contention runs.
module tb_trace_uart_arbiter;

   localparam int DEPTH = 16;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        trace_enable = 1'b0;
   logic [35:0] trace_data = '0;
   logic        trace_valid = 1'b0;
   logic        cpu_tx_valid = 1'b0;
   logic [7:0]  cpu_tx_data = '0;
   logic        cpu_tx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b0;
   logic [$clog2(DEPTH):0] fifo_level;
   logic [15:0] overflow_count;

   trace_uart_arbiter #(.FIFO_DEPTH(DEPTH), .FRAME_HEADER(8'hA5)) dut (
      .clock          (clock),
      .resetn         (resetn),
      .trace_enable   (trace_enable),
      .trace_data     (trace_data),
      .trace_valid    (trace_valid),
      .cpu_tx_valid   (cpu_tx_valid),
      .cpu_tx_data    (cpu_tx_data),
      .cpu_tx_ready   (cpu_tx_ready),
      .tx_valid       (tx_valid),
      .tx_data        (tx_data),
      .tx_ready       (tx_ready),
      .fifo_level     (fifo_level),
      .overflow_count (overflow_count)
   );

   always #5 clock = ~clock;

   // exp[0] is the first byte on the wire.
   typedef struct {
      logic             is_cpu;
      logic [35:0]      din;
      int               nbytes;
      logic [5:0][7:0]  exp;
      int               lat;
   } vec_t;

   vec_t        vecs[6];
   logic [7:0]  exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cpu_acc = 0;
   int          n_xfer = 0;
   bit          prev_stall = 0;
   logic [7:0]  prev_data = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every transfer must match the queue head; stalled bytes must hold.
   always @(negedge clock) begin
      if (!resetn) begin
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", 64'(tx_valid), 64'd1);
            chk("hold_data", 64'(tx_data), 64'(prev_data));
         end
         if (tx_valid && tx_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_byte: got %0h expected none", tx_data);
            end else begin
               chk("tx_byte", 64'(tx_data), 64'(exp_q.pop_front()));
            end
         end
         if (cpu_tx_ready) cpu_acc++;
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [35:0] mkword(input int k);
      logic [7:0] b;
      b = k[7:0];
      return {b[3:0] ^ 4'h5, b, 8'hC3, ~b, b + 8'd1};
   endfunction

   // Reference framing: header then little-endian bytes, top nibble zero-extended.
   task automatic push_frame(input logic [35:0] w);
      logic [39:0] t;
      t = {4'h0, w};
      exp_q.push_back(8'hA5);
      for (int i = 0; i < 5; i++) exp_q.push_back(t[8*i +: 8]);
   endtask

   task automatic write_word(input logic [35:0] w);
      trace_data  = w;
      trace_valid = 1'b1;
      tick();
      trace_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int budget, input bit toggle, output int cycles);
      int c;
      c = 0;
      while ((exp_q.size() != 0 || tx_valid || fifo_level != 0) && c < budget) begin
         if (toggle) tx_ready = (c % 3 == 2);
         tick();
         c++;
      end
      tx_ready = 1'b1;
      chk({name, "_left"}, 64'(exp_q.size()), 64'd0);
      chk({name, "_valid"}, 64'(tx_valid), 64'd0);
      chk({name, "_level"}, 64'(fifo_level), 64'd0);
      cycles = c;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int c;
      int base;

      vecs[0] = '{1'b0, 36'h9_8765_4321, 6, {8'h09, 8'h87, 8'h65, 8'h43, 8'h21, 8'hA5}, 7};
      vecs[1] = '{1'b0, 36'h0_0000_0000, 6, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5}, 7};
      vecs[2] = '{1'b0, 36'hF_FFFF_FFFF, 6, {8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hA5}, 7};
      vecs[3] = '{1'b1, 36'h0_0000_005A, 1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A}, 1};
      vecs[4] = '{1'b0, 36'h1_2345_6789, 6, {8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hA5}, 7};
      vecs[5] = '{1'b0, 36'hA_DEAD_BEEF, 6, {8'h0A, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hA5}, 7};

      // Reset values.
      resetn = 1'b0;
      tick(); tick();
      chk("rst_tx_valid", 64'(tx_valid), 64'd0);
      chk("rst_tx_data", 64'(tx_data), 64'd0);
      chk("rst_cpu_ready", 64'(cpu_tx_ready), 64'd0);
      chk("rst_level", 64'(fifo_level), 64'd0);
      chk("rst_overflow", 64'(overflow_count), 64'd0);
      resetn = 1'b1;
      trace_enable = 1'b1;
      tx_ready = 1'b1;
      tick();

      // Table of single transactions with tx_ready held high.
      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < vecs[i].nbytes; j++) exp_q.push_back(vecs[i].exp[j]);
         if (vecs[i].is_cpu) begin
            cpu_tx_data  = vecs[i].din[7:0];
            cpu_tx_valid = 1'b1;
            #1;
            c = 0;
            while (!cpu_tx_ready && c < 20) begin tick(); c++; end
            chk("cpu_ready_seen", 64'(cpu_tx_ready), 64'd1);
            tick();
            cpu_tx_valid = 1'b0;
         end else begin
            write_word(vecs[i].din);
         end
         wait_drain("vec", 50, 1'b0, cyc);
         chk("vec_latency", 64'(cyc), 64'(vecs[i].lat));
      end

      // Backpressure: tx_ready high one cycle in three.
      base = n_xfer;
      push_frame(36'h9_8765_4321);
      tx_ready = 1'b0;
      write_word(36'h9_8765_4321);
      wait_drain("bp", 100, 1'b1, cyc);
      chk("bp_bytes", 64'(n_xfer - base), 64'd6);

      // Overflow: 20 writes against a stalled output.
      tx_ready = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (k < 17) push_frame(mkword(k));
         trace_data  = mkword(k);
         trace_valid = 1'b1;
         tick();
      end
      trace_valid = 1'b0;
      tick();
      chk("ovf_level", 64'(fifo_level), 64'd16);
      chk("ovf_count", 64'(overflow_count), 64'd3);
      chk("ovf_stall_valid", 64'(tx_valid), 64'd1);
      chk("ovf_stall_hdr", 64'(tx_data), 64'hA5);
      base = n_xfer;
      tx_ready = 1'b1;
      wait_drain("ovf", 400, 1'b0, cyc);
      chk("ovf_bytes", 64'(n_xfer - base), 64'(17 * 6));

      // Enable gating: a buffered word still drains, gated pulses do nothing.
      push_frame(36'h3_0F0F_F0F0);
      write_word(36'h3_0F0F_F0F0);
      trace_enable = 1'b0;
      for (int k = 0; k < 5; k++) begin
         trace_data  = mkword(100 + k);
         trace_valid = 1'b1;
         tick();
         trace_valid = 1'b0;
         tick();
      end
      wait_drain("gate", 60, 1'b0, cyc);
      chk("gate_overflow", 64'(overflow_count), 64'd3);
      trace_enable = 1'b1;

      // Asynchronous reset after the third byte of a frame.
      push_frame(36'h5_1122_3344);
      push_frame(36'h6_5566_7788);
      base = n_xfer;
      write_word(36'h5_1122_3344);
      write_word(36'h6_5566_7788);
      c = 0;
      while (n_xfer < base + 3 && c < 40) begin tick(); c++; end
      chk("ar_three_bytes", 64'(n_xfer - base), 64'd3);
      #2;
      resetn = 1'b0;
      exp_q.delete();
      #1;
      chk("ar_tx_valid", 64'(tx_valid), 64'd0);
      chk("ar_tx_data", 64'(tx_data), 64'd0);
      chk("ar_level", 64'(fifo_level), 64'd0);
      chk("ar_overflow", 64'(overflow_count), 64'd0);
      tick(); tick();
      resetn = 1'b1;
      tick();
      push_frame(36'h7_CAFE_F00D);
      write_word(36'h7_CAFE_F00D);
      wait_drain("ar_next", 50, 1'b0, cyc);
      chk("ar_next_latency", 64'(cyc), 64'd7);

      // Contention: CPU wins first tie after reset, then strict alternation.
      resetn = 1'b0;
      exp_q.delete();
      tx_ready = 1'b0;
      cpu_tx_data = 8'h41;
      cpu_tx_valid = 1'b1;
      tick(); tick();
      resetn = 1'b1;
      cpu_acc = 0;
      exp_q.push_back(8'h41);
      push_frame(36'h2_AAAA_0001);
      exp_q.push_back(8'h41);
      push_frame(36'h4_BBBB_0002);
      write_word(36'h2_AAAA_0001);
      write_word(36'h4_BBBB_0002);
      tick();
      chk("ct_level", 64'(fifo_level), 64'd2);
      chk("ct_first_cpu", 64'(tx_data), 64'h41);
      chk("ct_acc_first", 64'(cpu_acc), 64'd1);
      tx_ready = 1'b1;
      c = 0;
      while (cpu_acc < 2 && c < 40) begin tick(); c++; end
      cpu_tx_valid = 1'b0;
      wait_drain("ct", 60, 1'b0, cyc);
      chk("ct_acc_total", 64'(cpu_acc), 64'd2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/trace_uart_arbiter.md
Name: trace_uart_arbiter

Overview:
- Shares the board's single UART transmit byte channel between the CPU's own serial output and a live stream of the core's 36-bit execution trace.
- Trace words from the core's trace_data/trace_valid outputs are buffered in a FIFO, framed, and serialized as bytes onto the UART TX byte interface.
- CPU bytes are interleaved only at frame boundaries.
- Sits in lfcpnx_evn between the core, the CPU UART byte port and the UART transmitter, so the core can be traced on hardware without a simulator.

Parameters:
FIFO_DEPTH, 16, trace-word FIFO entries; power of two, minimum 2.
FRAME_HEADER, 8'hA5, sync byte sent before every trace frame.

Ports:
clock  input  1  system clock; all logic on its rising edge.
resetn  input  1  asynchronous active-low reset.
trace_enable  input  1  1 = accept trace words into the FIFO.
trace_data  input  36  trace word from the core.
trace_valid  input  1  trace_data valid this cycle.
cpu_tx_valid  input  1  CPU has a byte to send.
cpu_tx_data  input  8  CPU byte.
cpu_tx_ready  output  1  one-cycle pulse: CPU byte accepted this cycle.
tx_valid  output  1  byte available to UART transmitter.
tx_data  output  8  byte to UART transmitter.
tx_ready  input  1  transmitter accepts tx_data this cycle.
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
overflow_count  output  16  trace words dropped on full FIFO; saturating.

Behaviour:
- Reset (async assert, sync release) clears:
  - state = IDLE
  - tx_valid = 0, tx_data = 0, cpu_tx_ready = 0
  - FIFO empty, fifo_level = 0, overflow_count = 0
  - last_grant = TRACE, so the CPU wins the first tie.
- Reset mid-frame discards the partial frame and all buffered words. No completion.
- FIFO write:
  - Occurs on a rising edge with trace_valid & trace_enable & (not full, or pop in same cycle).
  - Word is visible to the FSM the next cycle.
  - Full and no pop: the word is dropped and overflow_count increments. It holds at 16'hFFFF.
  - Write and pop in the same cycle while full: the write is accepted and the level is unchanged.
- trace_enable low: no new writes. Buffered words and any in-progress frame still drain.
- Output handshake:
  - A byte transfers on an edge with tx_valid & tx_ready.
  - tx_data is registered and held stable while tx_valid=1 and tx_ready=0.
  - tx_valid never deasserts without a transfer.
- FSM states: IDLE, CPU, HDR, DATA.
- IDLE:
  - trace_pend = FIFO non-empty; cpu_pend = cpu_tx_valid.
  - Only one pending: grant it.
  - Both pending: grant the requester opposite to last_grant (alternation, no starvation).
  - Grant CPU: cpu_tx_ready=1 for that cycle, tx_data <= cpu_tx_data, tx_valid <= 1, last_grant <= CPU, go to CPU.
  - Grant TRACE: pop the FIFO head into a 36-bit shift register, tx_data <= FRAME_HEADER, tx_valid <= 1, last_grant <= TRACE, go to HDR.
  - Neither pending: stay in IDLE, tx_valid=0.
- CPU: on transfer, tx_valid <= 0 and go to IDLE.
- HDR: on transfer, load tx_data <= word[7:0], set byte index = 0, go to DATA.
- DATA, on each transfer:
  - If index < 4: increment index and load the next byte.
    - Bytes are little-endian: word[15:8], [23:16], [31:24], then {4'h0, word[35:32]}.
  - If index = 4: tx_valid <= 0 and go to IDLE.
- Frame = 6 bytes, never interleaved with CPU bytes.
- Throughput: back-to-back with tx_ready stuck high:
  - CPU byte: 2 cycles (IDLE + CPU).
  - Trace frame: 7 cycles (IDLE + HDR + 5 DATA).
- cpu_tx_ready is asserted only in IDLE on a CPU grant. The CPU must hold cpu_tx_valid/cpu_tx_data until then.
- fifo_level is updated on the same edge as writes and pops.

Test Plan:
- Single trace word: trace 36'h9_8765_4321 with tx_ready=1 -> tx bytes A5, 21, 43, 65, 87, 09. tx_valid then low, fifo_level back to 0.
- Backpressure: same word, tx_ready toggling 1-of-3 cycles -> same 6 bytes in order, each tx_data stable while unaccepted, no duplicates.
- Contention: FIFO holds 2 words and CPU presents 8'h41 continuously in IDLE after reset -> order 41, frame0, 41, frame1. cpu_tx_ready pulses exactly once per 41.
- Overflow: tx_ready=0, trace_valid high for 20 cycles with DEPTH=16:
  - fifo_level = 16 (one word already popped into the frame register).
  - overflow_count = 3.
  - Release tx_ready -> 17 frames emitted.
- Enable gating: trace_enable=0 while trace_valid pulses 5 times -> no FIFO writes, overflow_count unchanged, no frames.
- Async reset mid-frame: assert resetn low after the 3rd frame byte -> tx_valid=0, fifo_level=0, overflow_count=0 immediately. After release, the next frame starts with A5.
